// File: rtl/softmax_seq_ctrl.sv
// Sequencing controller around a combinational softmax datapath: it collects a frame of
// logits, waits for the datapath to settle, then drains the results and reports their argmax.
module softmax_seq_ctrl #(
    parameter int DATAWIDTH = 11,
    parameter int ROWS      = 10,
    parameter int SETTLE    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATAWIDTH-1:0]          in_data,
    output logic [ROWS*DATAWIDTH-1:0]     sm_in,
    input  logic [ROWS*DATAWIDTH-1:0]     sm_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATAWIDTH-1:0]          out_data,
    output logic [$clog2(ROWS)-1:0]       out_index,
    output logic                          out_last,
    output logic [$clog2(ROWS)-1:0]       argmax,
    output logic                          argmax_valid,
    output logic                          busy
);

    localparam int              IW       = $clog2(ROWS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_SETTLE,
        ST_DRAIN
    } state_t;

    state_t                       r_state;
    logic [IW-1:0]                r_cnt;
    logic [IW-1:0]                r_idx;
    logic [3:0]                   r_settle;
    logic signed [DATAWIDTH-1:0]  r_logit  [ROWS];
    logic signed [DATAWIDTH-1:0]  r_result [ROWS];
    logic signed [DATAWIDTH-1:0]  r_max_val;
    logic [IW-1:0]                r_max_idx;
    logic [IW-1:0]                r_argmax;
    logic                         r_argmax_valid;

    logic signed [DATAWIDTH-1:0]  w_cur;
    logic                         w_new_max;
    logic [IW-1:0]                w_max_idx_nxt;

    // The first drained element seeds the running max; afterwards only a strictly larger
    // value moves it, so ties resolve to the lowest index.
    assign w_cur         = r_result[r_idx];
    assign w_new_max     = (r_idx == '0) || (w_cur > r_max_val);
    assign w_max_idx_nxt = w_new_max ? r_idx : r_max_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_COLLECT;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_settle       <= '0;
            r_max_val      <= '0;
            r_max_idx      <= '0;
            r_argmax       <= '0;
            r_argmax_valid <= 1'b0;
            // NOTE: the logit and result arrays are deliberately reset, because sm_in must
            // read zero after reset; this costs a reset on every storage flop.
            for (int i = 0; i < ROWS; i++) begin
                r_logit[i]  <= '0;
                r_result[i] <= '0;
            end
        end else begin
            r_argmax_valid <= 1'b0;
            if (frame_clear) begin
                r_state  <= ST_COLLECT;
                r_cnt    <= '0;
                r_idx    <= '0;
                r_settle <= '0;
            end else begin
                case (r_state)
                    ST_COLLECT: begin
                        if (in_valid) begin
                            r_logit[r_cnt] <= in_data;
                            if (r_cnt == LAST_IDX) begin
                                r_cnt    <= '0;
                                r_settle <= 4'(SETTLE);
                                r_state  <= ST_SETTLE;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        r_settle <= r_settle - 1'b1;
                        if (r_settle <= 4'd1) begin
                            for (int i = 0; i < ROWS; i++) begin
                                r_result[i] <= sm_out[i*DATAWIDTH +: DATAWIDTH];
                            end
                            r_settle <= '0;
                            r_state  <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (out_ready) begin
                            r_max_idx <= w_max_idx_nxt;
                            if (w_new_max) begin
                                r_max_val <= w_cur;
                            end
                            if (r_idx == LAST_IDX) begin
                                r_argmax       <= w_max_idx_nxt;
                                r_argmax_valid <= 1'b1;
                                r_idx          <= '0;
                                r_state        <= ST_COLLECT;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_COLLECT;
                endcase
            end
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_pack
        assign sm_in[g*DATAWIDTH +: DATAWIDTH] = r_logit[g];
    end

    assign in_ready     = (r_state == ST_COLLECT);
    assign out_valid    = (r_state == ST_DRAIN);
    assign out_data     = w_cur;
    assign out_index    = r_idx;
    assign out_last     = (r_state == ST_DRAIN) && (r_idx == LAST_IDX);
    assign argmax       = r_argmax;
    assign argmax_valid = r_argmax_valid;
    assign busy         = !((r_state == ST_COLLECT) && (r_cnt == '0));

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Bench for softmax_seq_ctrl: a stand-in monotonic datapath (2x+1) plus a frame-level model
// of logit slots, expected result stream and first-maximum argmax.
module tb_softmax_seq_ctrl;

    localparam int DW     = 11;
    localparam int ROWS   = 10;
    localparam int SETTLE = 1;
    localparam int IW     = $clog2(ROWS);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 frame_clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        in_data;
    logic [ROWS*DW-1:0]   sm_in;
    logic [ROWS*DW-1:0]   sm_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [IW-1:0]        out_index;
    logic                 out_last;
    logic [IW-1:0]        argmax;
    logic                 argmax_valid;
    logic                 busy;

    softmax_seq_ctrl #(.DATAWIDTH(DW), .ROWS(ROWS), .SETTLE(SETTLE)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_clear  (frame_clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .sm_in        (sm_in),
        .sm_out       (sm_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .argmax       (argmax),
        .argmax_valid (argmax_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_slot  [ROWS];
    logic [DW-1:0] frame_v [ROWS];
    int            m_argmax;
    bit            g_hold;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in softmax: any strictly monotonic map keeps the argmax meaning intact.
    function automatic logic [DW-1:0] f(input logic [DW-1:0] x);
        logic signed [31:0] t;
        t = $signed(x) * 2 + 1;
        return t[DW-1:0];
    endfunction

    always_comb begin
        sm_out = '0;
        for (int i = 0; i < ROWS; i++) sm_out[i*DW +: DW] = f(sm_in[i*DW +: DW]);
    end

    function automatic logic [ROWS*DW-1:0] pack_slots();
        logic [ROWS*DW-1:0] p;
        p = '0;
        for (int i = 0; i < ROWS; i++) p[i*DW +: DW] = m_slot[i];
        return p;
    endfunction

    function automatic int ref_argmax();
        int best;
        best = 0;
        for (int i = 1; i < ROWS; i++)
            if ($signed(f(m_slot[i])) > $signed(f(m_slot[best]))) best = i;
        return best;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; frame_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_sm_in", sm_in, 0);
        check("rst_argmax", argmax, 0);
        check("rst_argmax_valid", argmax_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < ROWS; i++) m_slot[i] = '0;
        m_argmax = 0;
        check("rst_in_ready", in_ready, 1);
    endtask

    // Streams the first n elements of frame_v; called and returns at a falling edge.
    task automatic send_frame(input int n, input bit gaps, input bit hold);
        int lat;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin in_valid = 1'b0; @(negedge clk); end
            end
            check("in_ready_collect", in_ready, 1);
            in_valid = 1'b1;
            in_data  = frame_v[i];
            m_slot[i] = frame_v[i];
            @(negedge clk);
        end
        if (hold) in_data = DW'($urandom);
        else in_valid = 1'b0;
        if (n == ROWS) begin
            check("sm_in_frame", sm_in, pack_slots());
            check("in_ready_settle", in_ready, 0);
            check("busy_settle", busy, 1);
            lat = 0;
            while (!out_valid && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            check("latency", lat, SETTLE);
        end
    endtask

    // Drains a frame; with stop_at >= 0 it returns at that index without handshaking it.
    task automatic drain(input int mode, input int stop_at);
        logic [DW-1:0] e [ROWS];
        int  k, cyc, exp_am;
        bit  rdy, tog;
        for (int i = 0; i < ROWS; i++) e[i] = f(m_slot[i]);
        exp_am = ref_argmax();
        k = 0; cyc = 0; tog = 1'b1;
        while (k < ROWS && cyc < 200) begin
            check("out_valid", out_valid, 1);
            check("out_index", out_index, k);
            check("out_data", out_data, e[k]);
            check("out_last", out_last, (k == ROWS - 1));
            check("in_ready_drain", in_ready, 0);
            if (g_hold) check("sm_in_stable", sm_in, pack_slots());
            if (k == stop_at) begin
                out_ready = 1'b0;
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       begin rdy = tog; tog = !tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (g_hold) in_data = DW'($urandom);
            @(negedge clk);
            cyc++;
            if (rdy) k++;
        end
        check("drain_done", k, ROWS);
        in_valid = 1'b0;
        check("argmax_pulse", argmax_valid, 1);
        check("argmax", argmax, exp_am);
        check("out_valid_after", out_valid, 0);
        check("in_ready_after", in_ready, 1);
        check("busy_after", busy, 0);
        m_argmax = exp_am;
        out_ready = 1'b0;
        @(negedge clk);
        check("argmax_pulse_end", argmax_valid, 0);
        check("argmax_hold", argmax, m_argmax);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        g_hold = 1'b0;
        do_reset();

        // Ascending logits, always ready.
        for (int i = 0; i < ROWS; i++) frame_v[i] = DW'(i);
        send_frame(ROWS, 1'b0, 1'b0);
        drain(0, -1);
        check("asc_argmax", argmax, 9);

        // All equal: tie goes to index 0.
        for (int i = 0; i < ROWS; i++) frame_v[i] = DW'(5);
        send_frame(ROWS, 1'b0, 1'b0);
        drain(0, -1);
        check("tie_argmax", argmax, 0);

        // Mixed signs, out_ready toggling.
        begin
            int vals [ROWS] = '{-1, 5, 2, 6, 4, -2, 0, 1, 7, 3};
            for (int i = 0; i < ROWS; i++) frame_v[i] = DW'(vals[i]);
        end
        send_frame(ROWS, 1'b0, 1'b0);
        drain(1, -1);
        check("mixed_argmax", argmax, 8);

        // frame_clear after 4 logits; a logit offered with the clear is dropped.
        for (int i = 0; i < ROWS; i++) frame_v[i] = DW'(int'($urandom_range(0, 40)) - 20);
        send_frame(4, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = DW'(123); frame_clear = 1'b1;
        @(negedge clk);
        frame_clear = 1'b0; in_valid = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_in_ready", in_ready, 1);
        check("clr_out_valid", out_valid, 0);
        check("clr_sm_in", sm_in, pack_slots());
        check("clr_argmax", argmax, m_argmax);
        check("clr_argmax_valid", argmax_valid, 0);
        for (int i = 0; i < ROWS; i++) frame_v[i] = DW'(9 - i);
        send_frame(ROWS, 1'b0, 1'b0);
        drain(0, -1);
        check("desc_argmax", argmax, 0);

        // frame_clear mid-drain wins over out_ready.
        for (int i = 0; i < ROWS; i++) frame_v[i] = DW'(int'($urandom_range(0, 400)) - 200);
        send_frame(ROWS, 1'b0, 1'b0);
        drain(0, 2);
        frame_clear = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        frame_clear = 1'b0; out_ready = 1'b0;
        check("dclr_out_valid", out_valid, 0);
        check("dclr_argmax", argmax, m_argmax);
        check("dclr_argmax_valid", argmax_valid, 0);
        check("dclr_busy", busy, 0);

        // Reset in the middle of a drain.
        for (int i = 0; i < ROWS; i++) frame_v[i] = DW'(int'($urandom_range(0, 400)) - 200);
        send_frame(ROWS, 1'b0, 1'b0);
        drain(0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("drst_out_valid", out_valid, 0);
        check("drst_sm_in", sm_in, 0);
        check("drst_argmax", argmax, 0);
        rst_n = 1'b1;
        for (int i = 0; i < ROWS; i++) m_slot[i] = '0;
        m_argmax = 0;
        check("drst_in_ready", in_ready, 1);
        for (int i = 0; i < ROWS; i++) frame_v[i] = DW'(-i);
        send_frame(ROWS, 1'b0, 1'b0);
        drain(0, -1);
        check("neg_argmax", argmax, 0);

        // in_valid held high through SETTLE and DRAIN.
        for (int i = 0; i < ROWS; i++) frame_v[i] = DW'(int'($urandom_range(0, 400)) - 200);
        g_hold = 1'b1;
        send_frame(ROWS, 1'b0, 1'b1);
        drain(2, -1);
        g_hold = 1'b0;

        // Random frames with input gaps and random back-pressure.
        for (int r = 0; r < 8; r++) begin
            int span;
            span = (r % 2 == 0) ? 4 : 200;
            for (int i = 0; i < ROWS; i++)
                frame_v[i] = DW'(int'($urandom_range(0, 2 * span)) - span);
            send_frame(ROWS, 1'b1, 1'b0);
            drain(2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/softmax_seq_ctrl.md
SOFTMAX_SEQ_CTRL -- requirements
Module: softmax_seq_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 11, width of one signed logit/probability element.
REQ-002 SHALL have parameter ROWS, default 10, elements per frame (class count).
REQ-003 SHALL have parameter SETTLE, default 1 (range 1..15), cycles allowed for the combinational softmax datapath to settle.
REQ-004 SHALL have one clock and a synchronous, active-low reset; port list follows.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 frame_clear  in  1  synchronous flush of the current frame.
REQ-008 in_valid  in  1  logit on in_data is valid.
REQ-009 in_ready  out  1  controller accepts a logit this cycle.
REQ-010 in_data  in  DATAWIDTH  signed logit.
REQ-011 sm_in  out  ROWS*DATAWIDTH  packed logit vector to softmax datapath; element i at [i*DATAWIDTH +: DATAWIDTH].
REQ-012 sm_out  in  ROWS*DATAWIDTH  packed softmax result from datapath, same packing.
REQ-013 out_valid  out  1  out_data/out_index valid.
REQ-014 out_ready  in  1  downstream accepts result element.
REQ-015 out_data  out  DATAWIDTH  signed result element.
REQ-016 out_index  out  $clog2(ROWS)  element index of out_data.
REQ-017 out_last  out  1  high with out_valid when out_index == ROWS-1.
REQ-018 argmax  out  $clog2(ROWS)  index of largest result of last completed frame.
REQ-019 argmax_valid  out  1  one-cycle pulse when argmax updates.
REQ-020 busy  out  1  high in any state other than COLLECT with zero elements accepted.

Function
REQ-021 SHALL implement states COLLECT, SETTLE, DRAIN.
REQ-022 COLLECT: in_ready=1; accept on in_valid&in_ready; write in_data to logit slot cnt; cnt++.
REQ-023 On acceptance of element ROWS-1: cnt->0, settle counter loads SETTLE, next state SETTLE.
REQ-024 sm_in SHALL be driven from logit registers only; slots are not cleared between frames, only overwritten.
REQ-025 SETTLE: in_ready=0, out_valid=0; counter decrements each cycle; in cycle where counter==1, result register loads sm_out and state -> DRAIN.
REQ-026 Latency: last logit accepted at edge T -> out_valid first high in cycle after edge T+SETTLE.
REQ-027 DRAIN: out_valid=1, out_data=result[idx], out_index=idx; on out_valid&out_ready idx++.
REQ-028 out_valid&~out_ready SHALL hold out_data, out_index, out_last stable.
REQ-029 Running max (signed compare, strict greater-than, so ties keep lowest index) SHALL update on each DRAIN handshake.
REQ-030 Handshake with out_last: argmax <= final max index, argmax_valid pulses next cycle, idx->0, state -> COLLECT.
REQ-031 in_ready SHALL be 0 in SETTLE and DRAIN; no input overlap with draining.
REQ-032 frame_clear (any state): next state COLLECT, cnt=0, idx=0, settle counter 0, out_valid=0; argmax/argmax_valid unchanged except argmax_valid forced 0; logit and result registers retained; a logit presented in the same cycle is dropped.
REQ-033 frame_clear SHALL take priority over in_valid and out_ready in the same cycle.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force state COLLECT, cnt=0, idx=0, all logit and result registers 0, sm_in=0, argmax=0, argmax_valid=0, out_valid=0, out_last=0, busy=0; in_ready=1 in the first cycle after release.
REQ-035 Reset SHALL take priority over frame_clear and abort any frame mid-collect, mid-settle or mid-drain without emitting further outputs.

Verification
REQ-036 Ascending logits 0..9 streamed back-to-back, out_ready=1 -> sm_in element i = i; out_valid after SETTLE+1 cycles; 10 handshakes indices 0..9, out_last on 9; argmax=9 with argmax_valid pulse.
REQ-037 All logits = 5 -> all out_data equal; argmax=0 (tie to lowest).
REQ-038 Logits {-1,5,2,6,4,-2,0,1,7,3} with out_ready toggling 1-0-1 -> outputs held while out_ready=0; order preserved; argmax=8.
REQ-039 frame_clear asserted after 4 logits, then full frame 9..0 -> first frame ignored; argmax=0; no extra handshakes.
REQ-040 rst_n low during DRAIN at index 3 -> next cycle out_valid=0, sm_in=0, in_ready=1 after release; subsequent frame 0,-1..-9 gives argmax=0.
REQ-041 in_valid held high during SETTLE/DRAIN -> in_ready=0, no logit slot overwritten (sm_in stable).
